// File: rtl/rr_link_arbiter.sv
// Round-robin arbiter feeding one 8-bit put/free output link.
// Each granted 32-bit packet is sent as four bytes, MSB first.
module rr_link_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0][31:0]  pkt_in,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      free_outbound,
    output logic                      put_outbound,
    output logic [7:0]                payload_outbound,
    output logic                      busy,
    output logic [CNT_W-1:0]          sent_count
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} state_t;

    state_t             state;
    logic [31:0]        shreg;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   cand;
    logic               found;
    logic               arb;

    // Search starts just after the last winner so every source gets a turn.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign arb = rst_b && en && (|req) && free_outbound &&
                 ((state == IDLE) || (state == B3));

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant
        assign grant[g] = arb && (win == PTR_W'(g));
    end

    assign busy             = (state != IDLE);
    assign put_outbound     = busy;
    assign payload_outbound = shreg[31:24];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            shreg      <= '0;
            ptr        <= PTR_W'(NUM_REQ - 1);
            sent_count <= '0;
        end else begin
            case (state)
                B0: begin state <= B1; shreg <= {shreg[23:0], 8'h00}; end
                B1: begin state <= B2; shreg <= {shreg[23:0], 8'h00}; end
                B2: begin state <= B3; shreg <= {shreg[23:0], 8'h00}; end
                default: begin
                    // IDLE and B3 share the launch path so back-to-back packets leave no gap.
                    if (arb) begin
                        state      <= B0;
                        shreg      <= pkt_in[win];
                        ptr        <= win;
                        sent_count <= sent_count + 1'b1;
                    end else begin
                        state <= IDLE;
                        shreg <= {shreg[23:0], 8'h00};
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/rr_link_arbiter.md
# rr_link_arbiter

Round-robin arbiter and serializer for one router output link. It shares the link among NUM_REQ packet sources (router input buffers). It selects one 32-bit packet at a time, pops it from its source with a one-cycle grant, and drives it onto the 8-bit put/free link as four consecutive bytes, MSB first. This matches the byte-serial protocol the node endpoints use for inbound payloads.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- CNT_W, default 16: width of the sent-packet counter.

- clk  input  1  clock
- rst_b  input  1  reset, asynchronous, active-low
- en  input  1  arbitration enable; low blocks new grants only
- req  input  NUM_REQ  req[i]=1: requester i holds a valid packet on pkt_in[i]
- pkt_in  input  NUM_REQ x 32  packet per requester: [31:28] sourceID, [27:24] destID, [23:0] data
- grant  output  NUM_REQ  one-hot, combinational; requester i pops its packet on the clock edge ending a cycle with grant[i]=1
- free_outbound  input  1  downstream can accept a new packet
- put_outbound  output  1  byte valid on payload_outbound
- payload_outbound  output  8  current byte
- busy  output  1  transfer in progress (state != IDLE)
- sent_count  output  CNT_W  packets launched since reset; wraps

## Operation
- States:
  - IDLE: put_outbound=0.
  - B0, B1, B2, B3: put_outbound=1; payload_outbound = shreg[31:24].
- Arbitration point: asserted in IDLE, or in B3. It requires en=1, |req=1 and free_outbound=1, all sampled that cycle.
  - Winner w = first i with req[i]=1, searching from (ptr+1) mod NUM_REQ upward with wrap-around.
  - grant[w]=1 combinationally.
  - On the edge: shreg <= pkt_in[w]; ptr <= w; sent_count <= sent_count+1; next state B0.
- B0→B1→B2→B3 unconditionally. Each step does shreg <= {shreg[23:0], 8'h00}.
- B3 with the arbitration point asserted: back-to-back transfer to B0 with a new grant.
- B3 otherwise: go to IDLE.
- IDLE otherwise: stay in IDLE.
- grant=0 in B0..B2, and whenever the arbitration point is not asserted.
- grant never has more than one bit set.
- free_outbound is checked only at the arbitration point. Deassertion during B0..B3 does not stall or abort the packet.
- req changes during B0..B2 have no effect; the packet is already latched.
- en=0 mid-transfer: the current packet completes, then the FSM goes to IDLE.
- req[w] may drop on the cycle after grant. The arbiter never re-reads a granted packet.
- Fairness: a continuously requesting source waits at most NUM_REQ-1 packets between grants.

## Timing
- Reset (async, immediate):
  - state=IDLE, shreg=0, ptr=NUM_REQ-1 (requester 0 has first priority).
  - sent_count=0, put_outbound=0, payload_outbound=8'h00, busy=0, grant=0.
- Reset mid-transfer: put_outbound drops in the same cycle. The partial packet is discarded and not retried.
- Latency: if grant is high in cycle N, bytes [31:24], [23:16], [15:8], [7:0] appear in cycles N+1..N+4 with put_outbound=1.
- Throughput: one packet per 4 cycles while back-to-back. Each IDLE gap costs at least 1 cycle.
- sent_count updates on the grant edge, so it is visible in cycle N+1.
- payload_outbound is a register output; grant is combinational from state, ptr, req, en and free_outbound.

## Test plan
- Single packet:
  - Stimulus: reset, then req=4'b0100, pkt_in[2]=32'h12ABCDEF, free=1, en=1.
  - Required: grant=4'b0100 for exactly one cycle; the next 4 cycles carry put=1 with bytes 12, AB, CD, EF; then put=0, busy=0, sent_count=1.
- Round-robin rotation:
  - Stimulus: req=4'b1111 held, free=1.
  - Required: grant order 0,1,2,3,0 at cycles N, N+4, N+8, N+12, N+16; put stays high continuously with no gap.
- Backpressure:
  - Stimulus: req=4'b0001, free=0 for 10 cycles, then free=1.
  - Required: no grant, put=0 while free=0; grant[0] in the first cycle with free=1; free dropping after that grant does not interrupt the 4 bytes.
- Enable gating:
  - Stimulus: req=4'b0011 with a transfer from requester 0 in B1; drop en.
  - Required: bytes of requester 0 complete; no grant to requester 1 until en=1; then grant[1].
- Async reset mid-packet:
  - Stimulus: assert rst_b=0 during B2.
  - Required: put=0, payload=00, sent_count=0 immediately; after release, requester 0 has priority with req=4'b1001.
- Counter wrap (CNT_W=4):
  - Stimulus: 17 packets.
  - Required: sent_count reads 1.
